data_mem_mmio: RTL and testbench
================================

// Module: data_mem_mmio
// PURPOSE
//  Data-side memory subsystem directly downstream of the CPU core. It consumes mem_write, data_memory_addr and
//  write_data, and returns read_data in the same cycle, so the single-cycle core needs no stall.
//  Holds a word RAM, a byte TX FIFO with a valid/ready sink port, and a compare timer with an irq output.
// PARAMETERS
//  RAM_WORDS   64  RAM depth in 32-bit words; power of 2
//  FIFO_DEPTH  8   TX FIFO entries; power of 2, >=2
//  TIMER_W     32  timer counter/compare width; <=32
// PORTS
//  clk               in   1   clock; all state updates on rising edge
//  reset             in   1   synchronous, active-high
//  mem_write         in   1   write strobe for this cycle's address
//  data_memory_addr  in   32  byte address from core
//  write_data        in   32  store data
//  read_data         out  32  load data; combinational from addr and current state
//  tx_data           out  8   FIFO head byte; 0 when empty
//  tx_valid          out  1   FIFO non-empty
//  tx_ready          in   1   sink accepts head this cycle
//  irq               out  1   timer match & irq_en
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high.
//  Decode. addr[1:0] ignored everywhere.
//   - RAM: addr[31]=0 and addr < RAM_WORDS*4; word = addr[log2(RAM_WORDS)+1:2].
//   - MMIO: addr[31:8]=24'h800000; register = addr[4:2].
//   - Anything else: reads 0, writes ignored.
//  RAM: write on edge when mem_write; async read; contents not reset. Read-during-write returns old data.
//  MMIO map (unused offsets read 0, writes ignored):
//   0x00 TXDATA  W: push write_data[7:0]; R: 0
//   0x04 TXSTAT  R: {count[..],5'b0,ovf,empty,full}, count in bits [8+:log2(FIFO_DEPTH)+1]; W: bit2=1 clears ovf
//   0x08 TCOUNT  R/W counter
//   0x0C TCMP    R/W compare value
//   0x10 TCTL    R: {29'b0,match,irq_en,en}; W: bit0 en, bit1 irq_en, bit2=1 clears match
//  FIFO:
//   - pop = tx_valid & tx_ready; push = TXDATA write & !full.
//   - full/empty are count-based on pre-edge state. A push while full is dropped and sets ovf, even when a pop
//     happens the same cycle.
//   - Simultaneous push and pop when not full or empty: both occur, count unchanged.
//   - A pushed byte appears on tx_valid/tx_data the next cycle. No combinational path from tx_ready to tx_valid.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - ovf set and clear in the same cycle: set wins.
//  Timer:
//   - When en: count==cmp -> next count=0, match<=1; else count+1, wrapping at 2^TIMER_W.
//   - A TCOUNT write overrides increment or reload that cycle.
//   - match set and clear in the same cycle: set wins.
//   - irq = match & irq_en, combinational from registers.
//  Reset: FIFO empty, ovf=0, count=cmp=0, en=irq_en=match=0 -> tx_valid=0, tx_data=0, irq=0.
//   - A reset mid-drain discards queued bytes. RAM is preserved.
// TESTING
//  RAM: write 0xDEADBEEF @0x10, read @0x10 and @0x13 -> both 0xDEADBEEF; read @0x14 -> prior content.
//  Out of range: write @RAM_WORDS*4, then read it -> 0. Read @0x8000_0014 -> 0.
//  FIFO: tx_ready=0, push 0x41,0x42,0x43 -> TXSTAT count=3; tx_ready=1 -> 0x41,0x42,0x43 on successive cycles,
//   then tx_valid=0, empty=1.
//  Overflow: tx_ready=0, push 9 bytes -> count=8, full=1, ovf=1, 9th byte absent; write TXSTAT bit2 -> ovf=0.
//  Timer: TCMP=3, TCTL=3 -> count 0,1,2,3,0; match=1, irq=1 after the first wrap; TCTL write 0x7 -> irq=0.
//  Reset with FIFO holding 2 bytes and the timer running -> next cycle tx_valid=0, irq=0, TCOUNT=0.

Source files
------------

// File: rtl/data_mem_mmio.sv
// Data-side memory subsystem for a single-cycle core: word RAM, byte TX FIFO
// with a valid/ready sink port, and a compare timer with an interrupt output.
// Loads are combinational so the core never stalls; all state updates on clk.
module data_mem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMER_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_memory_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    localparam logic [31:0]      RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        REG_TXDATA = 3'd0,
        REG_TXSTAT = 3'd1,
        REG_TCOUNT = 3'd2,
        REG_TCMP   = 3'd3,
        REG_TCTL   = 3'd4
    } mmio_reg_e;

    // ------------------------------------------------------------------
    // Address decode (addr[1:0] never affects selection of a word)
    // ------------------------------------------------------------------
    logic              ram_sel;
    logic              mmio_sel;
    logic [RAM_AW-1:0] ram_idx;
    mmio_reg_e         reg_sel;

    assign ram_sel  = !data_memory_addr[31] && (data_memory_addr < RAM_BYTES);
    assign mmio_sel = (data_memory_addr[31:8] == 24'h800000);
    assign ram_idx  = data_memory_addr[RAM_AW+1:2];
    assign reg_sel  = mmio_reg_e'(data_memory_addr[4:2]);

    logic wr_txdata;
    logic wr_txstat;
    logic wr_tcount;
    logic wr_tcmp;
    logic wr_tctl;

    assign wr_txdata = mem_write && mmio_sel && (reg_sel == REG_TXDATA);
    assign wr_txstat = mem_write && mmio_sel && (reg_sel == REG_TXSTAT);
    assign wr_tcount = mem_write && mmio_sel && (reg_sel == REG_TCOUNT);
    assign wr_tcmp   = mem_write && mmio_sel && (reg_sel == REG_TCMP);
    assign wr_tctl   = mem_write && mmio_sel && (reg_sel == REG_TCTL);

    // ------------------------------------------------------------------
    // Word RAM
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];

    // RAM write port; async read below returns pre-edge data on read-during-write.
    // NOTE: storage arrays are deliberately left out of reset so they map onto
    // RAM macros; only control state needs a known value after reset.
    always_ff @(posedge clk) begin
        if (mem_write && ram_sel) begin
            ram_q[ram_idx] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic               ovf_q, ovf_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (fcnt_q == FULL_CNT);
    assign fifo_empty = (fcnt_q == '0);
    assign push       = wr_txdata && !fifo_full;
    assign pop        = !fifo_empty && tx_ready;

    // FIFO pointer/count/overflow next state; a push into a full FIFO is
    // dropped even if the same edge pops, and its ovf set beats a clear.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through this block can leave it unassigned and infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fcnt_d   = fcnt_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - CNT_W'(1);
        end

        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_txstat && write_data[2]) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO control registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fcnt_q   <= fcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO byte storage; stale entries are hidden by the empty gating on tx_data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= write_data[7:0];
        end
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Compare timer
    // ------------------------------------------------------------------
    logic [TIMER_W-1:0] tcnt_q, tcnt_d;
    logic [TIMER_W-1:0] tcmp_q, tcmp_d;
    logic               en_q, en_d;
    logic               irq_en_q, irq_en_d;
    logic               match_q, match_d;
    logic               hit;

    assign hit = en_q && (tcnt_q == tcmp_q);

    // Timer next state; a TCOUNT write overrides increment/reload, and a
    // compare hit on the same edge as a match clear leaves match set.
    always_comb begin
        tcnt_d   = tcnt_q;
        tcmp_d   = tcmp_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        match_d  = match_q;

        if (wr_tcount) begin
            tcnt_d = write_data[TIMER_W-1:0];
        end else if (hit) begin
            tcnt_d = '0;
        end else if (en_q) begin
            tcnt_d = tcnt_q + TIMER_W'(1);
        end

        if (wr_tcmp) begin
            tcmp_d = write_data[TIMER_W-1:0];
        end

        if (wr_tctl) begin
            en_d     = write_data[0];
            irq_en_d = write_data[1];
        end

        if (hit) begin
            match_d = 1'b1;
        end else if (wr_tctl && write_data[2]) begin
            match_d = 1'b0;
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q   <= '0;
            tcmp_q   <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            tcmp_q   <= tcmp_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            match_q  <= match_d;
        end
    end

    assign irq = match_q && irq_en_q;

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    // Combinational read mux over RAM and MMIO registers; unmapped reads 0.
    always_comb begin
        read_data = 32'h0;
        if (ram_sel) begin
            read_data = ram_q[ram_idx];
        end else if (mmio_sel) begin
            case (reg_sel)
                REG_TXSTAT: begin
                    read_data[8 +: CNT_W] = fcnt_q;
                    read_data[2]          = ovf_q;
                    read_data[1]          = fifo_empty;
                    read_data[0]          = fifo_full;
                end
                REG_TCOUNT: read_data = 32'(tcnt_q);
                REG_TCMP:   read_data = 32'(tcmp_q);
                REG_TCTL:   read_data = {29'b0, match_q, irq_en_q, en_q};
                default:    read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios plus randomized
// traffic, all compared against a queue/array based behavioural model.
module tb_data_mem_mmio;

    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_memory_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    data_mem_mmio #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMER_W   (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_write       (mem_write),
        .data_memory_addr(data_memory_addr),
        .write_data      (write_data),
        .read_data       (read_data),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    // Reference model state
    logic [31:0] m_ram [RAM_WORDS];
    logic [7:0]  m_fifo [$];
    bit          m_ovf;
    logic [31:0] m_cnt, m_cmp;
    bit          m_en, m_irq_en, m_match;

    // Values observed in the most recent cycle
    logic [31:0] last_rd;
    logic [7:0]  last_txd;
    logic        last_txv;
    logic        last_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return (a[31] == 1'b0) && (a < RAM_WORDS * 4);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >> 8) == 32'h0080_0000;
    endfunction

    function automatic int reg_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h7);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int n;
        if (is_ram(a)) return m_ram[a / 4];
        if (!is_mmio(a)) return 32'h0;
        n = m_fifo.size();
        case (reg_of(a))
            1: return (n << 8) | (m_ovf << 2) | ((n == 0) << 1) | (n == FIFO_DEPTH);
            2: return m_cnt;
            3: return m_cmp;
            4: return (m_match << 2) | (m_irq_en << 1) | m_en;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge given the inputs held during the cycle.
    task automatic model_step(input bit rst, input bit we, input logic [31:0] a,
                              input logic [31:0] wd, input bit rdy);
        bit was_full, push_req, hit;
        int r;
        r = reg_of(a);
        if (we && is_ram(a)) m_ram[a / 4] = wd;
        if (rst) begin
            m_fifo.delete();
            m_ovf = 0; m_cnt = 0; m_cmp = 0;
            m_en = 0; m_irq_en = 0; m_match = 0;
            return;
        end
        was_full = (m_fifo.size() == FIFO_DEPTH);
        push_req = we && is_mmio(a) && r == 0;
        if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
        if (push_req && !was_full) m_fifo.push_back(wd[7:0]);
        if (push_req && was_full) m_ovf = 1;
        else if (we && is_mmio(a) && r == 1 && wd[2]) m_ovf = 0;

        hit = m_en && (m_cnt == m_cmp);
        if (we && is_mmio(a) && r == 2) m_cnt = wd;
        else if (hit) m_cnt = 0;
        else if (m_en) m_cnt = m_cnt + 1;
        if (we && is_mmio(a) && r == 3) m_cmp = wd;
        if (hit) m_match = 1;
        else if (we && is_mmio(a) && r == 4 && wd[2]) m_match = 0;
        if (we && is_mmio(a) && r == 4) begin
            m_en = wd[0];
            m_irq_en = wd[1];
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, then advance model.
    task automatic cyc(input bit rst, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit rdy, input bit chk = 1);
        reset = rst; mem_write = we; data_memory_addr = a;
        write_data = wd; tx_ready = rdy;
        #1;
        last_rd = read_data; last_txd = tx_data; last_txv = tx_valid; last_irq = irq;
        if (chk) begin
            check("read_data", read_data, model_read(a));
            check("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
            check("tx_data", 32'(tx_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
            check("irq", 32'(irq), 32'(m_match && m_irq_en));
        end
        @(posedge clk);
        model_step(rst, we, a, wd, rdy);
        @(negedge clk);
    endtask

    localparam logic [31:0] MMIO   = 32'h8000_0000;
    localparam logic [31:0] TXDATA = MMIO + 32'h00;
    localparam logic [31:0] TXSTAT = MMIO + 32'h04;
    localparam logic [31:0] TCOUNT = MMIO + 32'h08;
    localparam logic [31:0] TCMP   = MMIO + 32'h0C;
    localparam logic [31:0] TCTL   = MMIO + 32'h10;

    initial begin
        reset = 1'b1; mem_write = 1'b0; data_memory_addr = '0;
        write_data = '0; tx_ready = 1'b0;
        foreach (m_ram[i]) m_ram[i] = 'x;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0);

        // Reset state
        cyc(0, 0, TXSTAT, 0, 0);
        check("rst_txstat", last_rd, 32'h2);
        check("rst_txvalid", 32'(last_txv), 0);
        check("rst_irq", 32'(last_irq), 0);

        // Give every RAM word a known value
        for (int i = 0; i < RAM_WORDS; i++) cyc(0, 1, 32'(i * 4), $urandom, 0);

        // RAM: write, read, byte-offset read, neighbour untouched
        cyc(0, 1, 32'h10, 32'hDEADBEEF, 0);
        cyc(0, 0, 32'h10, 0, 0);
        check("ram_rd10", last_rd, 32'hDEADBEEF);
        cyc(0, 0, 32'h13, 0, 0);
        check("ram_rd13", last_rd, 32'hDEADBEEF);
        cyc(0, 0, 32'h14, 0, 0);

        // Out of range
        cyc(0, 1, 32'(RAM_WORDS * 4), 32'h12345678, 0);
        cyc(0, 0, 32'(RAM_WORDS * 4), 0, 0);
        check("oor_rd", last_rd, 0);
        cyc(0, 0, 32'h8000_0014, 0, 0);
        check("mmio_unused", last_rd, 0);

        // FIFO fill then drain
        cyc(0, 1, TXDATA, 32'h41, 0);
        cyc(0, 1, TXDATA, 32'h42, 0);
        cyc(0, 1, TXDATA, 32'h43, 0);
        cyc(0, 0, TXSTAT, 0, 0);
        check("fifo_cnt3", last_rd, 32'h300);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            check("fifo_head", 32'(last_txd), 32'h41 + 32'(i));
        end
        cyc(0, 0, TXSTAT, 0, 1);
        check("fifo_drained", last_rd, 32'h2);
        check("fifo_txv0", 32'(last_txv), 0);

        // Overflow: 9 pushes into 8 entries
        for (int i = 0; i < 9; i++) cyc(0, 1, TXDATA, 32'h60 + 32'(i), 0);
        cyc(0, 0, TXSTAT, 0, 0);
        check("ovf_stat", last_rd, 32'h805);
        cyc(0, 1, TXSTAT, 32'h4, 0);
        cyc(0, 0, TXSTAT, 0, 0);
        check("ovf_clr", last_rd, 32'h801);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, 1);
            check("ovf_drain", 32'(last_txd), 32'h60 + 32'(i));
        end
        cyc(0, 0, 0, 0, 0);
        check("ovf_9th_absent", 32'(last_txv), 0);

        // Timer: compare 3, run with irq enabled
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, TCMP, 3, 0);
        cyc(0, 1, TCTL, 3, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, TCOUNT, 0, 0);
            check("tmr_count", last_rd, 32'(i % 4));
        end
        check("tmr_irq", 32'(last_irq), 1);
        cyc(0, 1, TCTL, 7, 0);
        cyc(0, 0, TCTL, 0, 0);
        check("tmr_irq_clr", 32'(last_irq), 0);

        // Reset mid-drain with timer running
        cyc(0, 1, TXDATA, 32'hA1, 0);
        cyc(0, 1, TXDATA, 32'hA2, 0);
        cyc(0, 1, TCMP, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, TCOUNT, 0, 0);
        check("rst2_txv", 32'(last_txv), 0);
        check("rst2_irq", 32'(last_irq), 0);
        check("rst2_tcount", last_rd, 0);
        cyc(0, 0, 32'h10, 0, 0);
        check("rst2_ram_kept", last_rd, 32'hDEADBEEF);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, wd;
            bit we, rdy, rst;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)      a = $urandom_range(0, RAM_WORDS * 4 + 31);
            else if (sel < 9) a = MMIO + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            else              a = $urandom;
            we  = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            wd  = $urandom;
            if (is_mmio(a) && reg_of(a) inside {2, 3}) wd = $urandom_range(0, 12);
            if (is_mmio(a) && reg_of(a) == 4) wd = $urandom_range(0, 7) | 32'h1;
            cyc(rst, we, a, wd, rdy);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
